exe_stage_md: RTL
=================

// Module: exe_stage_md
// PURPOSE
//  Parametrised execute stage between decode and memory. Runs single-cycle ALU ops via the team alu (12-bit alu_op).
//  Adds an iterative multiply/divide unit, byte-lane store generation, flush, and a forwarding/busy port for the hazard unit.
//  Uses the valid/allow_in handshake of the in-order pipeline.
// PARAMETERS
//  XLEN     32  datapath width; 32 or 64
//  MUL_LAT  2   cycles a MUL occupies EXE; must be >= 1
//  NLANE    XLEN/8 (localparam)  byte lanes of data SRAM
// PORTS
//  clk             in   1      clock
//  rst             in   1      reset, synchronous, active-high
//  ds_to_es_valid  in   1      decode holds a valid instr
//  es_allow_in     out  1      EXE accepts a new instr this cycle
//  ds_op_kind      in   2      00 ALU, 01 MUL, 10 DIV, 11 reserved (treated as ALU)
//  ds_md_op        in   2      MUL: 00 low, 01 high signed, 10 high unsigned; DIV: 00 div.s, 01 mod.s, 10 div.u, 11 mod.u
//  ds_alu_op       in   12     one-hot ALU op
//  ds_src1/ds_src2 in   XLEN   operands
//  ds_st_data      in   XLEN   store data (rkd value)
//  ds_mem_we       in   1      store
//  ds_load         in   1      load: result goes to memory stage
//  ds_mem_size     in   2      0 byte, 1 half, 2 word, 3 dword (XLEN=64 only, else as word)
//  ds_rf_we        in   1      register write-back enable
//  ds_dest         in   5      destination register
//  ds_pc           in   32     instruction PC
//  flush           in   1      kill the instr in EXE
//  ms_allow_in     in   1      memory stage accepts
//  es_to_ms_valid  out  1      output bundle valid
//  es_result       out  XLEN   ALU/MUL/DIV result, or address for loads and stores
//  es_load, es_rf_we, es_dest, es_pc, es_mem_size  out  1/1/5/32/2  registered copies
//  data_sram_en    out  1      memory request strobe
//  data_sram_we    out  NLANE  byte write enables
//  data_sram_addr  out  XLEN   = ALU result
//  data_sram_wdata out  XLEN   lane-aligned store data
//  es_fwd_valid    out  1      es_valid & rf_we & ready_go & ~load
//  es_fwd_dest     out  5      dest for bypass
//  es_fwd_data     out  XLEN   = es_result
//  es_busy         out  1      es_valid & ~ready_go (hazard unit stalls)
// BEHAVIOUR
//  Reset: es_valid=0, FSM=IDLE, counter=0, captured fields=0; every output 0 except es_allow_in=1.
//  Capture: fields register on ds_to_es_valid & es_allow_in.
//  es_allow_in = ~es_valid | (ready_go & ms_allow_in).
//  es_to_ms_valid = es_valid & ready_go & ~flush.
//  Cycle 0 = first cycle with es_valid=1.
//   ALU: ready_go in cycle 0.
//   MUL: ready_go in cycle MUL_LAT-1. Full 2*XLEN product; selected half is registered.
//   DIV: restoring, one quotient bit per cycle in cycles 0..XLEN-1; ready_go in cycle XLEN.
//  FSM: IDLE -> MUL or DIV on capture of that kind -> DONE when the counter expires.
//   DONE -> IDLE, or straight to the next kind, when the bundle leaves.
//   DONE holds the result while ms_allow_in=0.
//   Back-to-back captures restart the counter with no bubble.
//  Signed div: operands made absolute first. Quotient negated if signs differ; remainder takes the dividend sign.
//  Div by zero: quotient all-ones, remainder = dividend.
//  Overflow (MIN / -1): quotient MIN, remainder 0.
//  Memory: data_sram_en = es_valid & (mem_we|load) & ms_allow_in & ~flush, so one request per instr.
//   data_sram_we is 0 unless mem_we and data_sram_en.
//  Lane offset o = addr[log2(NLANE)-1:0].
//   byte: we = 1<<o, data replicated every byte.
//   half: we = 2'b11 << (o & ~1), half replicated (o[0] ignored).
//   word: 4'hF << (o & ~3).
//   dword: all lanes.
//  flush: es_valid clears next cycle; FSM -> IDLE, counter=0; no SRAM request or es_to_ms_valid that cycle.
//   flush & capture in the same cycle: the new instr is captured (flush applies only to the current occupant).
//  rst mid-divide: FSM aborts and all state returns to reset values the next cycle.
// TESTING
//  1. ALU add 5+7, ms_allow_in=1: es_to_ms_valid cycle 0, es_result=12, es_allow_in stays 1.
//  2. div.s -7/2, then mod.s: results 0xFFFFFFFD, 0xFFFFFFFF; ready_go at cycle 32; es_busy=1 for cycles 0-31.
//  3. div.u 9/0 -> 0xFFFFFFFF; mod.u 9/0 -> 9; div.s 0x80000000/-1 -> 0x80000000.
//  4. Byte stores, data 0xAB, addr 0x1001 then 0x1003: we 4'b0010 then 4'b1000, wdata 0xABABABAB. Half store, addr 0x1002: we 4'b1100.
//  5. mulh.s 0xFFFFFFFF*2 with MUL_LAT=2 and ms_allow_in low 3 cycles: result 0xFFFFFFFF held; exactly one handoff.
//  6. flush in cycle 10 of a DIV: no es_to_ms_valid, no SRAM request, es_allow_in=1 next cycle; same test with XLEN=64 dword store (we=8'hFF).

Source files
------------

// File: rtl/exe_stage_md.sv
// Execute stage: single-cycle ALU, iterative multiply/divide, byte-lane store
// generation, flush, and forwarding/busy signals for the hazard unit.
module exe_stage_md #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ds_to_es_valid,
  output logic                es_allow_in,
  input  logic [1:0]          ds_op_kind,
  input  logic [1:0]          ds_md_op,
  input  logic [11:0]         ds_alu_op,
  input  logic [XLEN-1:0]     ds_src1,
  input  logic [XLEN-1:0]     ds_src2,
  input  logic [XLEN-1:0]     ds_st_data,
  input  logic                ds_mem_we,
  input  logic                ds_load,
  input  logic [1:0]          ds_mem_size,
  input  logic                ds_rf_we,
  input  logic [4:0]          ds_dest,
  input  logic [31:0]         ds_pc,
  input  logic                flush,
  input  logic                ms_allow_in,
  output logic                es_to_ms_valid,
  output logic [XLEN-1:0]     es_result,
  output logic                es_load,
  output logic                es_rf_we,
  output logic [4:0]          es_dest,
  output logic [31:0]         es_pc,
  output logic [1:0]          es_mem_size,
  output logic                data_sram_en,
  output logic [XLEN/8-1:0]   data_sram_we,
  output logic [XLEN-1:0]     data_sram_addr,
  output logic [XLEN-1:0]     data_sram_wdata,
  output logic                es_fwd_valid,
  output logic [4:0]          es_fwd_dest,
  output logic [XLEN-1:0]     es_fwd_data,
  output logic                es_busy
);
  localparam int unsigned NLANE   = XLEN / 8;
  localparam int unsigned LW      = $clog2(NLANE);
  localparam int unsigned SW      = $clog2(XLEN);
  localparam int unsigned CNT_MAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic              es_valid_q;
  logic [1:0]        kind_q, md_op_q, mem_size_q;
  logic [11:0]       alu_op_q;
  logic [XLEN-1:0]   src1_q, src2_q, st_data_q, mul_res_q;
  logic              mem_we_q, load_q, rf_we_q;
  logic [4:0]        dest_q;
  logic [31:0]       pc_q;
  logic [XLEN-1:0]   dvd_q, dvs_q, rem_q;
  logic              qneg_q, rneg_q, dz_q;

  logic              is_mul, is_div, ready_go, cap, leave;
  logic [XLEN-1:0]   alu_res, div_res, mul_sel, a_abs, b_abs, rem_d;
  logic              a_neg, b_neg, q_bit;
  logic [2*XLEN-1:0] prod_s, prod_u;
  logic [XLEN:0]     shifted, diff;
  logic [NLANE-1:0]  lane_we;
  logic [XLEN-1:0]   lane_wdata;
  logic [LW-1:0]     off;
  logic [1:0]        size_eff;
  logic [SW-1:0]     sh;

  assign is_mul   = (kind_q == 2'b01);
  assign is_div   = (kind_q == 2'b10);
  assign ready_go = (state_q == S_DONE)
                  | ((state_q == S_MUL) & (cnt_q == CW'(MUL_LAT - 1)))
                  | ((state_q == S_DIV) & (cnt_q == CW'(XLEN)))
                  | (~is_mul & ~is_div);
  assign es_allow_in = ~es_valid_q | (ready_go & ms_allow_in);
  assign cap   = ds_to_es_valid & es_allow_in;
  assign leave = es_valid_q & ready_go & ms_allow_in;

  // One-hot ALU: add sub slt sltu and nor or xor sll srl sra lui
  always_comb begin
    sh      = src2_q[SW-1:0];
    alu_res = '0;
    if (alu_op_q[0])  alu_res |= src1_q + src2_q;
    if (alu_op_q[1])  alu_res |= src1_q - src2_q;
    if (alu_op_q[2])  alu_res |= {{(XLEN-1){1'b0}}, $signed(src1_q) < $signed(src2_q)};
    if (alu_op_q[3])  alu_res |= {{(XLEN-1){1'b0}}, src1_q < src2_q};
    if (alu_op_q[4])  alu_res |= src1_q & src2_q;
    if (alu_op_q[5])  alu_res |= ~(src1_q | src2_q);
    if (alu_op_q[6])  alu_res |= src1_q | src2_q;
    if (alu_op_q[7])  alu_res |= src1_q ^ src2_q;
    if (alu_op_q[8])  alu_res |= src1_q << sh;
    if (alu_op_q[9])  alu_res |= src1_q >> sh;
    if (alu_op_q[10]) alu_res |= $unsigned($signed(src1_q) >>> sh);
    if (alu_op_q[11]) alu_res |= src2_q;
  end

  // Capture-time operand preparation for MUL (full product) and DIV (magnitudes)
  always_comb begin
    prod_s = {{XLEN{ds_src1[XLEN-1]}}, ds_src1} * {{XLEN{ds_src2[XLEN-1]}}, ds_src2};
    prod_u = {{XLEN{1'b0}}, ds_src1} * {{XLEN{1'b0}}, ds_src2};
    case (ds_md_op)
      2'b01:   mul_sel = prod_s[2*XLEN-1:XLEN];
      2'b10:   mul_sel = prod_u[2*XLEN-1:XLEN];
      default: mul_sel = prod_u[XLEN-1:0];
    endcase
    a_neg = ~ds_md_op[1] & ds_src1[XLEN-1];
    b_neg = ~ds_md_op[1] & ds_src2[XLEN-1];
    a_abs = a_neg ? -ds_src1 : ds_src1;
    b_abs = b_neg ? -ds_src2 : ds_src2;
  end

  // Restoring divide step and sign fix-up of the final quotient/remainder
  always_comb begin
    shifted = {rem_q, dvd_q[XLEN-1]};
    diff    = shifted - {1'b0, dvs_q};
    q_bit   = ~diff[XLEN];
    rem_d   = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    if (md_op_q[0])  div_res = rneg_q ? -rem_q : rem_q;
    else if (dz_q)   div_res = '1;
    else             div_res = qneg_q ? -dvd_q : dvd_q;
  end

  // Byte-lane enables and replicated store data
  always_comb begin
    off      = alu_res[LW-1:0];
    size_eff = ((mem_size_q == 2'd3) && (XLEN == 32)) ? 2'd2 : mem_size_q;
    case (size_eff)
      2'd0: begin
        lane_we    = NLANE'(1) << off;
        lane_wdata = {NLANE{st_data_q[7:0]}};
      end
      2'd1: begin
        lane_we    = NLANE'(3) << (off & ~LW'(1));
        lane_wdata = {(NLANE/2){st_data_q[15:0]}};
      end
      2'd2: begin
        lane_we    = NLANE'(15) << (off & ~LW'(3));
        lane_wdata = {(XLEN/32){st_data_q[31:0]}};
      end
      default: begin
        lane_we    = '1;
        lane_wdata = st_data_q;
      end
    endcase
  end

  assign es_result       = is_mul ? mul_res_q : (is_div ? div_res : alu_res);
  assign es_to_ms_valid  = es_valid_q & ready_go & ~flush;
  assign es_load         = load_q;
  assign es_rf_we        = rf_we_q;
  assign es_dest         = dest_q;
  assign es_pc           = pc_q;
  assign es_mem_size     = mem_size_q;
  assign data_sram_en    = es_valid_q & (mem_we_q | load_q) & ms_allow_in & ~flush;
  assign data_sram_we    = (data_sram_en & mem_we_q) ? lane_we : '0;
  assign data_sram_addr  = alu_res;
  assign data_sram_wdata = lane_wdata;
  assign es_fwd_valid    = es_valid_q & rf_we_q & ready_go & ~load_q;
  assign es_fwd_dest     = dest_q;
  assign es_fwd_data     = es_result;
  assign es_busy         = es_valid_q & ~ready_go;

  // Pipeline register, MUL/DIV sequencer and divider datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      es_valid_q <= 1'b0;
      kind_q     <= '0;
      md_op_q    <= '0;
      alu_op_q   <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      st_data_q  <= '0;
      mem_we_q   <= 1'b0;
      load_q     <= 1'b0;
      mem_size_q <= '0;
      rf_we_q    <= 1'b0;
      dest_q     <= '0;
      pc_q       <= '0;
      mul_res_q  <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      dz_q       <= 1'b0;
    end else if (cap) begin
      es_valid_q <= 1'b1;
      kind_q     <= ds_op_kind;
      md_op_q    <= ds_md_op;
      alu_op_q   <= ds_alu_op;
      src1_q     <= ds_src1;
      src2_q     <= ds_src2;
      st_data_q  <= ds_st_data;
      mem_we_q   <= ds_mem_we;
      load_q     <= ds_load;
      mem_size_q <= ds_mem_size;
      rf_we_q    <= ds_rf_we;
      dest_q     <= ds_dest;
      pc_q       <= ds_pc;
      mul_res_q  <= mul_sel;
      dvd_q      <= a_abs;
      dvs_q      <= b_abs;
      rem_q      <= '0;
      qneg_q     <= a_neg ^ b_neg;
      rneg_q     <= a_neg;
      dz_q       <= (ds_src2 == '0);
      cnt_q      <= '0;
      state_q    <= (ds_op_kind == 2'b01) ? S_MUL : ((ds_op_kind == 2'b10) ? S_DIV : S_IDLE);
    end else if (flush | leave) begin
      es_valid_q <= 1'b0;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        S_MUL: begin
          if (cnt_q == CW'(MUL_LAT - 1)) state_q <= S_DONE;
          else                           cnt_q   <= cnt_q + CW'(1);
        end
        S_DIV: begin
          if (cnt_q == CW'(XLEN)) begin
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            dvd_q <= {dvd_q[XLEN-2:0], q_bit};
            rem_q <= rem_d;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
